// File: rtl/pipeline_trace_if.sv
// Fetch-side and retirement-side signals of the pipeline trace tracker.
// The master modport is the tracker. The slave modport is the fetch source and the trace consumer.
interface pipeline_trace_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned PC_W       = 16,
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned TS_W       = 32
);
    logic                        fetch_valid;
    logic [PC_W-1:0]             fetch_pc;
    logic [INSTR_W-1:0]          fetch_instr;
    logic                        fetch_accept;
    logic                        ret_valid;
    logic                        ret_ready;
    logic [PC_W-1:0]             ret_pc;
    logic [INSTR_W-1:0]          ret_instr;
    logic [TS_W-1:0]             ret_cycle;
    logic [NUM_STAGES*CNT_W-1:0] ret_stalls;

    modport master (
        input  fetch_valid, fetch_pc, fetch_instr, ret_ready,
        output fetch_accept, ret_valid, ret_pc, ret_instr, ret_cycle, ret_stalls
    );

    modport slave (
        output fetch_valid, fetch_pc, fetch_instr, ret_ready,
        input  fetch_accept, ret_valid, ret_pc, ret_instr, ret_cycle, ret_stalls
    );
endinterface

// File: rtl/pipeline_trace_tracker.sv
// Shadows an N-stage pipeline from its stall/flush vectors and tags every instruction with its PC, its encoding and a stall count for each stage.
// Each retired instruction produces one record, which is queued in a first-word-fall-through FIFO.
module pipeline_trace_tracker #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned PC_W       = 16,
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned TS_W       = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_trace_if.master      trk,
    input  logic [NUM_STAGES-1:0] stall,
    input  logic [NUM_STAGES-1:0] flush,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [15:0]           flush_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = NUM_STAGES * CNT_W;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [TS_W-1:0]    cyc;
        logic [SW-1:0]      stalls;
    } rec_t;

    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] valid_q, valid_d, src_valid;
    logic [PC_W-1:0]       pc_q [NUM_STAGES];
    logic [PC_W-1:0]       pc_d [NUM_STAGES];
    logic [PC_W-1:0]       src_pc [NUM_STAGES];
    logic [INSTR_W-1:0]    instr_q [NUM_STAGES];
    logic [INSTR_W-1:0]    instr_d [NUM_STAGES];
    logic [INSTR_W-1:0]    src_instr [NUM_STAGES];
    logic [SW-1:0]         cnt_q [NUM_STAGES];
    logic [SW-1:0]         cnt_d [NUM_STAGES];
    logic [SW-1:0]         src_cnt [NUM_STAGES];
    logic [TS_W-1:0]       cyc_q, cyc_d;
    logic [15:0]           flush_cnt_q, flush_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [16:0]           fsum;
    rec_t                  mem_q [FIFO_DEPTH];
    rec_t                  new_rec, head;
    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic                  retire, full, empty, pop, push, drop;

    // A stalled stage also freezes every stage in front of it.
    always_comb begin
        hold = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            hold[k] = |(stall >> k);
        end
    end

    always_comb begin
        src_valid[0] = trk.fetch_valid;
        src_pc[0]    = trk.fetch_pc;
        src_instr[0] = trk.fetch_instr;
        src_cnt[0]   = '0;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            src_valid[k] = valid_q[k-1] & ~hold[k-1] & ~flush[k-1];
            src_pc[k]    = pc_q[k-1];
            src_instr[k] = instr_q[k-1];
            src_cnt[k]   = cnt_q[k-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        fsum    = {1'b0, flush_cnt_q};
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            pc_d[k]    = pc_q[k];
            instr_d[k] = instr_q[k];
            cnt_d[k]   = cnt_q[k];
            if (flush[k]) begin
                valid_d[k] = 1'b0;
                if (valid_q[k]) fsum = fsum + 17'd1;
            end else if (hold[k]) begin
                if (valid_q[k] && cnt_q[k][k*CNT_W +: CNT_W] != '1)
                    cnt_d[k][k*CNT_W +: CNT_W] = cnt_q[k][k*CNT_W +: CNT_W] + CNT_W'(1);
            end else begin
                valid_d[k] = src_valid[k];
                pc_d[k]    = src_pc[k];
                instr_d[k] = src_instr[k];
                cnt_d[k]   = src_cnt[k];
            end
        end
        flush_cnt_d = fsum[16] ? 16'hFFFF : fsum[15:0];
    end

    // The pointers carry one extra wrap bit, which separates the full state from the empty state.
    assign retire = valid_q[NUM_STAGES-1] & ~flush[NUM_STAGES-1] & ~hold[NUM_STAGES-1];
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop    = ~empty & trk.ret_ready;
    assign push   = retire & (~full | pop);
    assign drop   = retire & full & ~pop;

    always_comb begin
        new_rec    = '{pc: pc_q[NUM_STAGES-1], instr: instr_q[NUM_STAGES-1],
                       cyc: cyc_q, stalls: cnt_q[NUM_STAGES-1]};
        wptr_d     = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d     = pop ? rptr_q + PTR_ONE : rptr_q;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        overflow_d = overflow_q | drop;
        cyc_d      = cyc_q + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= '0;
            cyc_q       <= '0;
            flush_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            cyc_q       <= cyc_d;
            flush_cnt_q <= flush_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    // Payload is only observed behind a valid bit or a non-empty FIFO.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            pc_q[k]    <= pc_d[k];
            instr_q[k] <= instr_d[k];
            cnt_q[k]   <= cnt_d[k];
        end
        if (push) mem_q[wptr_q[AW-1:0]] <= new_rec;
    end

    assign head             = mem_q[rptr_q[AW-1:0]];
    assign trk.fetch_accept = ~hold[0];
    assign trk.ret_valid    = ~empty;
    assign trk.ret_pc       = empty ? '0 : head.pc;
    assign trk.ret_instr    = empty ? '0 : head.instr;
    assign trk.ret_cycle    = empty ? '0 : head.cyc;
    assign trk.ret_stalls   = empty ? '0 : head.stalls;
    assign stage_valid      = valid_q;
    assign flush_cnt        = flush_cnt_q;
    assign drop_cnt         = drop_cnt_q;
    assign overflow         = overflow_q;
endmodule

// File: tb/tb_pipeline_trace_tracker.sv
// Directed testbench for pipeline_trace_tracker with its default parameters: 5 stages, 4-bit stall counters and a 4-entry FIFO.
// Each cycle is counted from the reset edge, at which the cycle counter becomes 0.
module tb_pipeline_trace_tracker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  stall = '0;
    logic [4:0]  flush = '0;
    logic [4:0]  stage_valid;
    logic [15:0] flush_cnt, drop_cnt;
    logic        overflow;
    int          vecs = 0;
    int          errs = 0;

    pipeline_trace_if #(.NUM_STAGES(5), .PC_W(16), .INSTR_W(16), .CNT_W(4), .TS_W(32)) bus ();

    pipeline_trace_tracker #(
        .NUM_STAGES(5), .PC_W(16), .INSTR_W(16), .CNT_W(4), .TS_W(32), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trk(bus), .stall(stall), .flush(flush),
        .stage_valid(stage_valid), .flush_cnt(flush_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fetch(input logic [15:0] pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        bus.fetch_instr = pc ^ 16'h5A5A;
    endtask

    task automatic do_reset();
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.ret_ready   = 1'b0;
        stall = '0;
        flush = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (stage_valid !== 5'b0) begin errs++; $display("FAIL reset_stage_valid: got %b want 00000", stage_valid); end
        vecs++; if (bus.ret_valid !== 1'b0) begin errs++; $display("FAIL reset_ret_valid: got %b want 0", bus.ret_valid); end
        vecs++; if (bus.ret_pc !== 16'h0 || bus.ret_cycle !== 32'h0 || bus.ret_stalls !== 20'h0)
            begin errs++; $display("FAIL reset_ret_fields: pc=%h cyc=%0d st=%h want zeros", bus.ret_pc, bus.ret_cycle, bus.ret_stalls); end
        vecs++; if (flush_cnt !== 16'h0 || drop_cnt !== 16'h0 || overflow !== 1'b0)
            begin errs++; $display("FAIL reset_counters: flush=%0d drop=%0d ovf=%b want 0 0 0", flush_cnt, drop_cnt, overflow); end
        vecs++; if (bus.fetch_accept !== 1'b1) begin errs++; $display("FAIL reset_accept: got %b want 1", bus.fetch_accept); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_pc;
        logic        exp_v;
        do_reset();
        bus.ret_ready = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            if (n <= 8) drive_fetch(16'(n - 1));
            else bus.fetch_valid = 1'b0;
            tick();
            exp_v = (n >= 6) && (n <= 13);
            vecs++; if (bus.ret_valid !== exp_v)
                begin errs++; $display("FAIL b2b_valid edge %0d: got %b want %b", n, bus.ret_valid, exp_v); end
            if (exp_v) begin
                exp_pc = 16'(n - 6);
                vecs++;
                if (bus.ret_pc !== exp_pc || bus.ret_instr !== (exp_pc ^ 16'h5A5A) ||
                    bus.ret_cycle !== 32'(n - 1) || bus.ret_stalls !== 20'h0) begin
                    errs++;
                    $display("FAIL b2b_record edge %0d: pc=%h instr=%h cyc=%0d st=%h want pc=%h cyc=%0d st=0",
                             n, bus.ret_pc, bus.ret_instr, bus.ret_cycle, bus.ret_stalls, exp_pc, n - 1);
                end
            end
            if (n == 5) begin
                vecs++; if (stage_valid !== 5'b11111) begin errs++; $display("FAIL b2b_full_pipe: got %b want 11111", stage_valid); end
            end
        end
    endtask

    task automatic test_stall_decode();
        do_reset();
        bus.ret_ready = 1'b1;
        drive_fetch(16'h0010); tick();
        drive_fetch(16'h0011); tick();
        bus.fetch_valid = 1'b0;
        stall = 5'b00010;
        #1;
        vecs++; if (bus.fetch_accept !== 1'b0) begin errs++; $display("FAIL stall_accept: got %b want 0", bus.fetch_accept); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (stage_valid !== 5'b00011)
                begin errs++; $display("FAIL stall_bubble %0d: stage_valid=%b want 00011", i, stage_valid); end
        end
        stall = '0;
        tick(); tick(); tick();
        vecs++; if (bus.ret_valid !== 1'b0) begin errs++; $display("FAIL stall_early_ret: got %b want 0", bus.ret_valid); end
        tick();
        vecs++; if (bus.ret_valid !== 1'b1 || bus.ret_pc !== 16'h0010 || bus.ret_stalls !== 20'h00030 || bus.ret_cycle !== 32'd8)
            begin errs++; $display("FAIL stall_rec_decode: v=%b pc=%h st=%h cyc=%0d want 1 0010 00030 8",
                                   bus.ret_valid, bus.ret_pc, bus.ret_stalls, bus.ret_cycle); end
        tick();
        vecs++; if (bus.ret_valid !== 1'b1 || bus.ret_pc !== 16'h0011 || bus.ret_stalls !== 20'h00003 || bus.ret_cycle !== 32'd9)
            begin errs++; $display("FAIL stall_rec_fetch: v=%b pc=%h st=%h cyc=%0d want 1 0011 00003 9",
                                   bus.ret_valid, bus.ret_pc, bus.ret_stalls, bus.ret_cycle); end
        tick();
        vecs++; if (bus.ret_valid !== 1'b0) begin errs++; $display("FAIL stall_drain: got %b want 0", bus.ret_valid); end
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        drive_fetch(16'h0020); tick();
        drive_fetch(16'h0021); tick();
        bus.fetch_valid = 1'b0;
        flush = 5'b00011;
        stall = 5'b00010;
        tick();
        flush = '0;
        stall = '0;
        vecs++; if (stage_valid !== 5'b0) begin errs++; $display("FAIL flush_kill: stage_valid=%b want 00000", stage_valid); end
        vecs++; if (flush_cnt !== 16'd2) begin errs++; $display("FAIL flush_cnt: got %0d want 2", flush_cnt); end
        bus.ret_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ret_valid === 1'b1) seen++;
        end
        vecs++; if (seen !== 0) begin errs++; $display("FAIL flush_no_retire: got %0d records want 0", seen); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int n = 1; n <= 11; n++) begin
            if (n <= 6) drive_fetch(16'h0030 + 16'(n - 1));
            else bus.fetch_valid = 1'b0;
            tick();
            if (n >= 6) begin
                vecs++; if (bus.ret_valid !== 1'b1 || bus.ret_pc !== 16'h0030 || bus.ret_cycle !== 32'd5)
                    begin errs++; $display("FAIL ovf_head_stable edge %0d: v=%b pc=%h cyc=%0d want 1 0030 5",
                                           n, bus.ret_valid, bus.ret_pc, bus.ret_cycle); end
            end
            if (n == 9) begin
                vecs++; if (drop_cnt !== 16'd0 || overflow !== 1'b0)
                    begin errs++; $display("FAIL ovf_not_yet: drop=%0d ovf=%b want 0 0", drop_cnt, overflow); end
            end
            if (n == 10) begin
                vecs++; if (drop_cnt !== 16'd1 || overflow !== 1'b1)
                    begin errs++; $display("FAIL ovf_first_drop: drop=%0d ovf=%b want 1 1", drop_cnt, overflow); end
            end
        end
        vecs++; if (drop_cnt !== 16'd2 || overflow !== 1'b1)
            begin errs++; $display("FAIL ovf_drop_cnt: drop=%0d ovf=%b want 2 1", drop_cnt, overflow); end
        bus.ret_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vecs++; if (bus.ret_valid !== 1'b1 || bus.ret_pc !== 16'h0030 + 16'(i) || bus.ret_cycle !== 32'(5 + i))
                begin errs++; $display("FAIL ovf_pop %0d: v=%b pc=%h cyc=%0d want 1 %h %0d",
                                       i, bus.ret_valid, bus.ret_pc, bus.ret_cycle, 16'h0030 + 16'(i), 5 + i); end
            tick();
        end
        vecs++; if (bus.ret_valid !== 1'b0 || overflow !== 1'b1)
            begin errs++; $display("FAIL ovf_empty: v=%b ovf=%b want 0 1", bus.ret_valid, overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            if (n <= 5) drive_fetch(16'h0040 + 16'(n - 1));
            else bus.fetch_valid = 1'b0;
            tick();
        end
        bus.ret_ready = 1'b1;
        tick();
        vecs++; if (drop_cnt !== 16'd0 || overflow !== 1'b0)
            begin errs++; $display("FAIL pushpop_drop: drop=%0d ovf=%b want 0 0", drop_cnt, overflow); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (bus.ret_valid !== 1'b1 || bus.ret_pc !== 16'h0041 + 16'(i) || bus.ret_cycle !== 32'(6 + i))
                begin errs++; $display("FAIL pushpop_entry %0d: v=%b pc=%h cyc=%0d want 1 %h %0d",
                                       i, bus.ret_valid, bus.ret_pc, bus.ret_cycle, 16'h0041 + 16'(i), 6 + i); end
            tick();
        end
        vecs++; if (bus.ret_valid !== 1'b0) begin errs++; $display("FAIL pushpop_empty: got %b want 0", bus.ret_valid); end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        bus.ret_ready = 1'b1;
        drive_fetch(16'h0070); tick();
        bus.fetch_valid = 1'b0;
        repeat (4) tick();
        stall = 5'b10000;
        #1;
        vecs++; if (bus.fetch_accept !== 1'b0) begin errs++; $display("FAIL sat_accept: got %b want 0", bus.fetch_accept); end
        repeat (17) tick();
        vecs++; if (stage_valid !== 5'b10000 || bus.ret_valid !== 1'b0)
            begin errs++; $display("FAIL sat_held: stage_valid=%b v=%b want 10000 0", stage_valid, bus.ret_valid); end
        stall = '0;
        tick();
        vecs++; if (bus.ret_valid !== 1'b1 || bus.ret_pc !== 16'h0070 || bus.ret_stalls !== 20'hF0000 || bus.ret_cycle !== 32'd22)
            begin errs++; $display("FAIL sat_record: v=%b pc=%h st=%h cyc=%0d want 1 0070 F0000 22",
                                   bus.ret_valid, bus.ret_pc, bus.ret_stalls, bus.ret_cycle); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            drive_fetch(16'h0050 + 16'(n - 1));
            tick();
        end
        bus.fetch_valid = 1'b0;
        flush = 5'b00001;
        tick();
        flush = '0;
        vecs++; if (stage_valid !== 5'b11100 || bus.ret_pc !== 16'h0050 || flush_cnt !== 16'd1)
            begin errs++; $display("FAIL mid_pre: stage_valid=%b pc=%h flush=%0d want 11100 0050 1",
                                   stage_valid, bus.ret_pc, flush_cnt); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vecs++; if (bus.ret_valid !== 1'b0 || stage_valid !== 5'b0 || bus.ret_pc !== 16'h0)
            begin errs++; $display("FAIL mid_clear: v=%b stage_valid=%b pc=%h want 0 00000 0000",
                                   bus.ret_valid, stage_valid, bus.ret_pc); end
        vecs++; if (flush_cnt !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0)
            begin errs++; $display("FAIL mid_counters: flush=%0d drop=%0d ovf=%b want 0 0 0", flush_cnt, drop_cnt, overflow); end
        bus.ret_ready = 1'b1;
        drive_fetch(16'h0060); tick();
        bus.fetch_valid = 1'b0;
        seen = 0;
        for (int n = 2; n <= 6; n++) begin
            tick();
            if (bus.ret_valid === 1'b1 && n != 6) seen++;
        end
        vecs++; if (seen !== 0) begin errs++; $display("FAIL mid_stale: got %0d early records want 0", seen); end
        vecs++; if (bus.ret_valid !== 1'b1 || bus.ret_pc !== 16'h0060 || bus.ret_cycle !== 32'd5)
            begin errs++; $display("FAIL mid_cycle_restart: v=%b pc=%h cyc=%0d want 1 0060 5",
                                   bus.ret_valid, bus.ret_pc, bus.ret_cycle); end
    endtask

    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.ret_ready   = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall_decode();
        test_flush();
        test_overflow();
        test_full_push_pop();
        test_stall_saturate();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
